// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle-latency instruction ROM.
// Issues sequential fetches, buffers returning words in a small skid FIFO, handles redirects.
module rom_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_AW     = 10,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [31:0]       rom_readdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc
);

  localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_L   = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_L    = PW'(FIFO_DEPTH - 1);
  localparam logic [31:0]     RESET_PCA = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   addr_q [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_L) ? '0 : p + PW'(1);
  endfunction

  // Occupancy counts the word still in flight so a returning response always has a slot.
  always_comb begin
    pop       = instr_valid & instr_ready;
    occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = ~reset & ~redirect_valid & (occupancy < DEPTH_L);
    push      = inflight_q & ~redirect_valid;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PCA;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= rom_readdata;
      addr_q[wr_ptr_q] <= inflight_pc_q;
    end
  end

  assign rom_address    = pc_q[ROM_AW+1:2];
  assign rom_chipselect = issue;
  assign rom_clken      = issue;
  assign instr_valid    = (count_q != '0);
  assign instr_data     = data_q[rd_ptr_q];
  assign instr_pc       = addr_q[rd_ptr_q];

endmodule
